// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges the in-order pipeline writeback
// with a queued secondary requester. A starvation counter forces the queue
// to drain periodically. A write-after-write guard stalls the pipeline while
// an older queued write to the same register is still pending.
module wb_port_arbiter #(
   parameter int DATA_W       = 16,
   parameter int ADDR_W       = 4,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wb_valid,
   input  logic [ADDR_W-1:0]             wb_rd,
   input  logic [DATA_W-1:0]             wb_data,
   output logic                          stall_pipe,
   input  logic                          sec_valid,
   output logic                          sec_ready,
   input  logic [ADDR_W-1:0]             sec_rd,
   input  logic [DATA_W-1:0]             sec_data,
   output logic                          rf_we,
   output logic [ADDR_W-1:0]             rf_waddr,
   output logic [DATA_W-1:0]             rf_wdata,
   input  logic [ADDR_W-1:0]             query_addr,
   output logic                          query_hit,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int STARVE_W = $clog2(STARVE_LIMIT) + 1;

   typedef enum logic {NORMAL, FORCE} state_t;

   logic [ADDR_W-1:0]     mem_rd   [FIFO_DEPTH];
   logic [DATA_W-1:0]     mem_data [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] entry_valid;
   logic [PTR_W-1:0]      wr_ptr, rd_ptr;
   logic [CNT_W-1:0]      count;
   state_t                state, state_next;
   logic [STARVE_W-1:0]   starve_cnt, starve_next;
   logic                  fifo_empty, fifo_full;
   logic                  push, pop, grant_wb, waw_hit;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
   // Never accept while in reset, and never when full, even if a pop is due.
   assign sec_ready  = rst_n && !fifo_full;
   assign push       = sec_valid && sec_ready;
   assign fifo_count = count;

   // Address match of the pipeline request and the decode query against live entries.
   always_comb begin
      waw_hit   = 1'b0;
      query_hit = rf_we && (rf_waddr == query_addr);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if (entry_valid[i] && wb_valid && (mem_rd[i] == wb_rd))
            waw_hit = 1'b1;
         if (entry_valid[i] && (mem_rd[i] == query_addr))
            query_hit = 1'b1;
      end
   end

   // Grant selection in priority order, plus the starvation next state.
   always_comb begin
      // NOTE: every signal driven here is defaulted first so that no path
      // leaves a value unassigned and no latch is inferred.
      state_next  = NORMAL;
      starve_next = starve_cnt;
      pop         = 1'b0;
      grant_wb    = 1'b0;
      stall_pipe  = 1'b0;
      if (state == FORCE) begin
         pop        = !fifo_empty;
         stall_pipe = 1'b1;
      end else if (waw_hit) begin
         pop        = 1'b1;
         stall_pipe = 1'b1;
      end else if (wb_valid) begin
         grant_wb = 1'b1;
      end else if (!fifo_empty) begin
         pop = 1'b1;
      end

      if (fifo_empty || pop) begin
         starve_next = '0;
      end else if (starve_cnt == STARVE_W'(STARVE_LIMIT - 1)) begin
         state_next = FORCE;
      end else begin
         starve_next = starve_cnt + STARVE_W'(1);
      end
   end

   // Arbiter state and starvation counter.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block ordering.
      if (!rst_n) begin
         state      <= NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
      end
   end

   // Queue control: pointers, occupancy and per-entry valid flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         entry_valid <= '0;
      end else begin
         if (push) begin
            entry_valid[wr_ptr] <= 1'b1;
            wr_ptr              <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            entry_valid[rd_ptr] <= 1'b0;
            rd_ptr              <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Queue storage.
   always_ff @(posedge clk) begin
      // NOTE: the storage array has no reset; entry_valid alone decides
      // whether a slot is live, so stale contents are never observed.
      if (push) begin
         mem_rd[wr_ptr]   <= sec_rd;
         mem_data[wr_ptr] <= sec_data;
      end
   end

   // One-cycle registered write port; address and data hold when idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= pop || grant_wb;
         if (pop) begin
            rf_waddr <= mem_rd[rd_ptr];
            rf_wdata <= mem_data[rd_ptr];
         end else if (grant_wb) begin
            rf_waddr <= wb_rd;
            rf_wdata <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a table of single-cycle vectors, each
// with expected combinational outputs before the edge and expected registered
// outputs after it, plus hand sequences for starvation and mid-run reset.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid;
   logic [3:0]  wb_rd;
   logic [15:0] wb_data;
   logic        stall_pipe;
   logic        sec_valid;
   logic        sec_ready;
   logic [3:0]  sec_rd;
   logic [15:0] sec_data;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [3:0]  query_addr;
   logic        query_hit;
   logic [2:0]  fifo_count;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(
      .DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(4), .STARVE_LIMIT(8)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_pipe(stall_pipe),
      .sec_valid(sec_valid), .sec_ready(sec_ready),
      .sec_rd(sec_rd), .sec_data(sec_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .query_addr(query_addr), .query_hit(query_hit),
      .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wv;
      logic [3:0]  wrd;
      logic [15:0] wd;
      logic        sv;
      logic [3:0]  srd;
      logic [15:0] sd;
      logic [3:0]  qa;
      logic        e_stall;
      logic        e_rdy;
      logic        e_qhit;
      logic        e_we;
      logic [3:0]  e_waddr;
      logic [15:0] e_wdata;
      logic [2:0]  e_cnt;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic wv, input logic [3:0] wrd, input logic [15:0] wd,
                        input logic sv, input logic [3:0] srd, input logic [15:0] sd,
                        input logic [3:0] qa);
      wb_valid = wv; wb_rd = wrd; wb_data = wd;
      sec_valid = sv; sec_rd = srd; sec_data = sd;
      query_addr = qa;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // wv wrd wd       sv srd sd       qa | stall rdy qhit | we waddr wdata    cnt
      vecs[0]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h0, 0, 1, 0, 0, 4'h0, 16'h0000, 3'd0};
      vecs[1]  = '{1, 4'h3, 16'h1234, 0, 4'h0, 16'h0000, 4'h0, 0, 1, 0, 1, 4'h3, 16'h1234, 3'd0};
      vecs[2]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h3, 0, 1, 1, 0, 4'h3, 16'h1234, 3'd0};
      vecs[3]  = '{0, 4'h0, 16'h0000, 1, 4'h5, 16'hBEEF, 4'h3, 0, 1, 0, 0, 4'h3, 16'h1234, 3'd1};
      vecs[4]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 0, 1, 1, 1, 4'h5, 16'hBEEF, 3'd0};
      vecs[5]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 0, 1, 1, 0, 4'h5, 16'hBEEF, 3'd0};
      vecs[6]  = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h5, 0, 1, 0, 0, 4'h5, 16'hBEEF, 3'd0};
      // Fill the queue while the pipeline owns the port.
      vecs[7]  = '{1, 4'h1, 16'h0101, 1, 4'h2, 16'h0002, 4'h0, 0, 1, 0, 1, 4'h1, 16'h0101, 3'd1};
      vecs[8]  = '{1, 4'h1, 16'h0102, 1, 4'h7, 16'h0001, 4'h0, 0, 1, 0, 1, 4'h1, 16'h0102, 3'd2};
      vecs[9]  = '{1, 4'h1, 16'h0103, 1, 4'hA, 16'h000A, 4'h0, 0, 1, 0, 1, 4'h1, 16'h0103, 3'd3};
      vecs[10] = '{1, 4'h1, 16'h0104, 1, 4'hB, 16'h000B, 4'h0, 0, 1, 0, 1, 4'h1, 16'h0104, 3'd4};
      // Full: fifth push refused; pipeline rd=7 collides, older rd=2 then rd=7 drain first.
      vecs[11] = '{1, 4'h7, 16'h7777, 1, 4'hC, 16'h000C, 4'hB, 1, 0, 1, 1, 4'h2, 16'h0002, 3'd3};
      vecs[12] = '{1, 4'h7, 16'h7777, 0, 4'h0, 16'h0000, 4'h0, 1, 1, 0, 1, 4'h7, 16'h0001, 3'd2};
      vecs[13] = '{1, 4'h7, 16'h7777, 0, 4'h0, 16'h0000, 4'hC, 0, 1, 0, 1, 4'h7, 16'h7777, 3'd2};
      vecs[14] = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h7, 0, 1, 1, 1, 4'hA, 16'h000A, 3'd1};
      vecs[15] = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h0, 0, 1, 0, 1, 4'hB, 16'h000B, 3'd0};
      // Push into empty, then simultaneous push and pop keeps the count.
      vecs[16] = '{0, 4'h0, 16'h0000, 1, 4'h3, 16'h0033, 4'h0, 0, 1, 0, 0, 4'hB, 16'h000B, 3'd1};
      vecs[17] = '{0, 4'h0, 16'h0000, 1, 4'h4, 16'h0044, 4'h0, 0, 1, 0, 1, 4'h3, 16'h0033, 3'd1};
      vecs[18] = '{0, 4'h0, 16'h0000, 0, 4'h0, 16'h0000, 4'h0, 0, 1, 0, 1, 4'h4, 16'h0044, 3'd0};

      rst_n = 1'b0;
      drive(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 4'h0);
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].wv, vecs[i].wrd, vecs[i].wd, vecs[i].sv, vecs[i].srd, vecs[i].sd, vecs[i].qa);
         #1;
         check($sformatf("v%0d stall_pipe", i), 32'(stall_pipe), 32'(vecs[i].e_stall));
         check($sformatf("v%0d sec_ready", i),  32'(sec_ready),  32'(vecs[i].e_rdy));
         check($sformatf("v%0d query_hit", i),  32'(query_hit),  32'(vecs[i].e_qhit));
         tick();
         check($sformatf("v%0d rf_we", i),      32'(rf_we),      32'(vecs[i].e_we));
         check($sformatf("v%0d rf_waddr", i),   32'(rf_waddr),   32'(vecs[i].e_waddr));
         check($sformatf("v%0d rf_wdata", i),   32'(rf_wdata),   32'(vecs[i].e_wdata));
         check($sformatf("v%0d fifo_count", i), 32'(fifo_count), 32'(vecs[i].e_cnt));
      end

      // Starvation: entry pushed in cycle 0 alongside a continuous pipeline
      // stream; eight pipeline writes while it waits, one forced drain
      // (stall, re-presented pipeline data), then the pipeline resumes.
      for (int k = 0; k <= 10; k++) begin
         logic [15:0] d;
         d = 16'h0200 + 16'((k < 9) ? k : 9);
         drive(1, 4'h1, d, (k == 0), 4'h9, 16'h0099, 4'h0);
         #1;
         check($sformatf("starve k%0d stall_pipe", k), 32'(stall_pipe), 32'(k == 9));
         tick();
         check($sformatf("starve k%0d rf_we", k),    32'(rf_we),    32'(1));
         check($sformatf("starve k%0d rf_waddr", k), 32'(rf_waddr), (k == 9) ? 32'h9 : 32'h1);
         check($sformatf("starve k%0d rf_wdata", k), 32'(rf_wdata), (k == 9) ? 32'h0099 : 32'(d));
      end

      // Mid-run reset discards three queued entries without writing them.
      for (int k = 0; k < 3; k++) begin
         drive(1, 4'h1, 16'h0300, 1, 4'(5 + k), 16'h0050, 4'h0);
         tick();
      end
      check("prereset fifo_count", 32'(fifo_count), 32'd3);
      rst_n = 1'b0;
      drive(0, 4'h0, 16'h0, 0, 4'h0, 16'h0, 4'h6);
      #1;
      check("in reset sec_ready", 32'(sec_ready), 32'd0);
      tick();
      check("reset fifo_count", 32'(fifo_count), 32'd0);
      check("reset rf_we", 32'(rf_we), 32'd0);
      check("reset rf_waddr", 32'(rf_waddr), 32'd0);
      check("reset query_hit", 32'(query_hit), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("post reset k%0d sec_ready", k), 32'(sec_ready), 32'd1);
         tick();
         check($sformatf("post reset k%0d rf_we", k), 32'(rf_we), 32'd0);
         check($sformatf("post reset k%0d fifo_count", k), 32'(fifo_count), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (MEM/WB register output after the writeback select mux) and a secondary out-of-band requester (multi-cycle unit / late load return) with valid/ready handshake. Secondary writes are queued in a small FIFO. A starvation counter and write-after-write (WAW) protection stall the pipeline when needed. Sits between the writeback stage and the register file; also gives decode a pending-write query for hazard stalls.

Parameters:
DATA_W, 16, width of write data
ADDR_W, 4, register address width (16 registers)
FIFO_DEPTH, 4, secondary request queue depth (power of 2, >=2)
STARVE_LIMIT, 8, consecutive non-granted cycles with FIFO non-empty before forced drain

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
wb_valid  input  1  pipeline writeback request this cycle
wb_rd  input  ADDR_W  pipeline destination register
wb_data  input  DATA_W  pipeline writeback data (mux result)
stall_pipe  output  1  combinational; pipeline holds MEM/WB contents and re-presents its request next cycle
sec_valid  input  1  secondary request valid
sec_ready  output  1  FIFO can accept (count < FIFO_DEPTH); 0 while rst_n=0
sec_rd  input  ADDR_W  secondary destination register
sec_data  input  DATA_W  secondary data
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  ADDR_W  register-file write address (registered)
rf_wdata  output  DATA_W  register-file write data (registered)
query_addr  input  ADDR_W  decode source-register query
query_hit  output  1  combinational; query_addr matches a valid FIFO entry or (rf_we && rf_waddr)
fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n=0 at posedge): rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, FIFO flushed, starve_cnt=0, state=NORMAL. Reset mid-operation discards queued entries without writing them.
- Push: sec_valid && sec_ready at posedge enqueues {sec_rd, sec_data}. No bypass when full; sec_ready=0 at count==FIFO_DEPTH, even if a pop happens the same cycle. Push and pop in the same cycle are allowed when not full; the count is unchanged.
- waw_hit = wb_valid && wb_rd matches any valid FIFO entry.
- States: NORMAL, FORCE.
- Grant priority, evaluated in this order:
  (1) state==FORCE: grant FIFO head; stall_pipe=1; next state NORMAL; starve_cnt cleared.
  (2) waw_hit: grant FIFO head; stall_pipe=1. Repeats each cycle until no match, so older secondary writes land first.
  (3) wb_valid: grant pipeline; stall_pipe=0.
  (4) FIFO non-empty: grant FIFO head.
  (5) Otherwise no grant.
- stall_pipe = (state==FORCE) || waw_hit. A wb request presented while stall_pipe=1 is not written.
- starve_cnt:
  - Increments on cycles where the FIFO is non-empty and the FIFO is not granted.
  - Clears on a FIFO grant or when the FIFO is empty.
  - When starve_cnt reaches STARVE_LIMIT-1 and the FIFO is again not granted, next state is FORCE.
  - The counter saturates and never wraps.
- Write port latency: the grant in cycle N appears on rf_we/rf_waddr/rf_wdata in cycle N+1 (one register stage). rf_we=0 in cycles with no grant. rf_waddr and rf_wdata hold their last value when rf_we=0.
- FIFO pointers wrap modulo FIFO_DEPTH. Entries are written in strict FIFO order.
- query_hit compares against all valid entries plus the in-flight output register. Entries are invalid after pop or reset.

Test Plan:
- Reset then idle → rf_we=0, fifo_count=0, sec_ready=1, stall_pipe=0; reset asserted with 3 queued entries → fifo_count=0 next cycle, no writes emitted.
- Pipeline only: wb_valid=1, wb_rd=3, wb_data=16'h1234 at cycle N → rf_we=1, rf_waddr=3, rf_wdata=16'h1234 at N+1; stall_pipe stays 0.
- Idle pipeline: push sec_rd=5, data 16'hBEEF → written in the cycle after the push, fifo_count returns 0; push 4 entries back-to-back → sec_ready=0 at count 4, a 5th sec_valid is not accepted.
- Starvation (STARVE_LIMIT=8): 1 FIFO entry, wb_valid=1 with rd≠FIFO rd continuously → 8 pipeline writes, then 1 cycle stall_pipe=1 with the FIFO entry written, then pipeline writes resume.
- WAW: FIFO holds rd=7 (16'h0001) and rd=2; wb_valid with wb_rd=7 → stall_pipe=1 and FIFO entries drain in order until rd=7 is written; the pipeline rd=7 write follows after both, so the final value is the pipeline data.
- query_addr=9 with a pending FIFO entry rd=9 → query_hit=1; query_hit stays 1 through the output register cycle, then 0.
